// File: rtl/core_array_pkg.sv
// Shared types and constants for the systolic-array tile sequencer.
package core_array_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StClear = 3'd1;
  localparam state_t StFeed  = 3'd2;
  localparam state_t StFlush = 3'd3;
  localparam state_t StDrain = 3'd4;
  localparam state_t StDone  = 3'd5;

  localparam logic MODE_88 = 1'b0;  // south drain, ROWS shifts
  localparam logic MODE_18 = 1'b1;  // east drain, COLS shifts

  // Cycles needed to push the operand skew and the DSP pipeline through the array.
  function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols,
                                            input int unsigned mult_lat);
    return rows + cols + mult_lat - 2;
  endfunction

endpackage

// File: rtl/core_array_tile_ctrl_if.sv
// Request/status and array-control bundle of the tile sequencer.
interface core_array_tile_ctrl_if #(
  parameter int unsigned K_WIDTH = 16
);
  logic               start;
  logic               mode_in;
  logic [K_WIDTH-1:0] k_len;
  logic               acc_keep;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               feed_en;
  logic               mode;
  logic               reset_pre;
  logic               en_pre;
  logic               cell_out_en_pre;
  logic               out_valid;

  modport master (
    output start, mode_in, k_len, acc_keep, out_ready,
    input  busy, done, feed_en, mode, reset_pre, en_pre, cell_out_en_pre, out_valid
  );

  modport slave (
    input  start, mode_in, k_len, acc_keep, out_ready,
    output busy, done, feed_en, mode, reset_pre, en_pre, cell_out_en_pre, out_valid
  );
endinterface

// File: rtl/ctrl_delay_line.sv
// Fixed-depth single-bit delay line; also reports whether any stage is still occupied.
module ctrl_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic pending
);

  logic [DEPTH-1:0] stages_q, stages_d;

  // Shift din into stage 0, every other stage takes its predecessor.
  always_comb begin
    stages_d    = stages_q;
    stages_d[0] = din;
    for (int i = 1; i < int'(DEPTH); i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  // Stage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) stages_q <= '0;
    else       stages_q <= stages_d;
  end

  assign dout    = stages_q[DEPTH-1];
  assign pending = |stages_q;

endmodule

// File: rtl/core_array_tile_ctrl.sv
// Tile sequencer: clear, feed, flush and drain phases for the MAC systolic array.
module core_array_tile_ctrl
  import core_array_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned K_WIDTH   = 16,
  parameter int unsigned MULT_LAT  = 3,
  parameter int unsigned DRAIN_LAT = 2
) (
  input logic                  clk,
  input logic                  reset,
  core_array_tile_ctrl_if.slave bus
);

  localparam int unsigned MinW     = $clog2(ROWS + COLS + MULT_LAT) + 1;
  localparam int unsigned CntW     = (K_WIDTH > MinW) ? K_WIDTH : MinW;
  localparam int unsigned FlushLen = flush_len(ROWS, COLS, MULT_LAT);

  state_t             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [K_WIDTH-1:0] klen_q, klen_d;
  logic               pipe_pending;
  logic               out_valid;
  logic               shift_en;
  logic               done;

  assign shift_en = (state_q == StDrain) && bus.out_ready;
  assign done     = (state_q == StDone) && !pipe_pending;

  // Next-state and down-counter; counters load N-1 on phase entry and exit at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    klen_d  = klen_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d = bus.mode_in;
          klen_d = bus.k_len;
          if (!bus.acc_keep) begin
            state_d = StClear;
          end else if (bus.k_len == '0) begin
            state_d = StFlush;
            cnt_d   = CntW'(FlushLen - 1);
          end else begin
            state_d = StFeed;
            cnt_d   = CntW'(bus.k_len) - CntW'(1);
          end
        end
      end
      StClear: begin
        if (klen_q == '0) begin
          state_d = StFlush;
          cnt_d   = CntW'(FlushLen - 1);
        end else begin
          state_d = StFeed;
          cnt_d   = CntW'(klen_q) - CntW'(1);
        end
      end
      StFeed: begin
        if (cnt_q == '0) begin
          state_d = StFlush;
          cnt_d   = CntW'(FlushLen - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFlush: begin
        if (cnt_q == '0) begin
          state_d = StDrain;
          cnt_d   = (mode_q == MODE_18) ? CntW'(COLS - 1) : CntW'(ROWS - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDrain: begin
        // A paused cycle holds the remaining shift count.
        if (shift_en) begin
          if (cnt_q == '0) state_d = StDone;
          else             cnt_d   = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= MODE_88;
      klen_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      klen_q  <= klen_d;
    end
  end

  ctrl_delay_line #(
    .DEPTH (DRAIN_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .reset   (reset),
    .din     (shift_en),
    .dout    (out_valid),
    .pending (pipe_pending)
  );

  assign bus.busy            = (state_q != StIdle);
  assign bus.done            = done;
  assign bus.feed_en         = (state_q == StFeed);
  assign bus.mode            = mode_q;
  assign bus.reset_pre       = (state_q == StClear);
  assign bus.en_pre          = (state_q == StFeed) || (state_q == StFlush);
  assign bus.cell_out_en_pre = shift_en;
  assign bus.out_valid       = out_valid;

endmodule

// File: tb/tb_core_array_tile_ctrl.sv
// Randomized bench for core_array_tile_ctrl against a phase-queue reference model.
module tb_core_array_tile_ctrl;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 6;
  localparam int unsigned KW     = 8;
  localparam int unsigned ML     = 3;
  localparam int unsigned DL     = 2;
  localparam int          FLUSH  = ROWS + COLS - 2 + ML;
  localparam int          NCYC   = 4000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_array_tile_ctrl_if #(.K_WIDTH(KW)) bus ();

  core_array_tile_ctrl #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .K_WIDTH   (KW),
    .MULT_LAT  (ML),
    .DRAIN_LAT (DL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a tile is a list of per-cycle phases, then a ready-gated drain.
  // Phase codes: 0 clear, 1 feed, 2 flush.
  bit  m_active;
  bit  m_mode;
  byte ph_q[$];
  int  vt_q[$];       // cycles at which out_valid must be high
  int  drain_left;
  int  last_valid;
  int  done_seen;

  task automatic model_reset();
    m_active   = 1'b0;
    m_mode     = 1'b0;
    ph_q.delete();
    vt_q.delete();
    drain_left = 0;
    last_valid = -100;
  endtask

  initial begin
    logic e_busy, e_done, e_feed, e_en, e_rst, e_coe, e_valid;
    done_seen     = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.mode_in   = 1'b0;
    bus.k_len     = '0;
    bus.acc_keep  = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NCYC; i++) begin
      cyc = i;
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      // Drive this cycle's inputs.
      if (i < 60) begin
        // Directed opening tile: mode 0, k=5, clear, start held during busy and in done cycle.
        reset         = 1'b0;
        bus.start     = (i == 0) || (i >= 5 && i < 10) || (i == 24) || (i == 40);
        bus.mode_in   = (i == 40);
        bus.k_len     = (i == 40) ? KW'(0) : KW'(5);
        bus.acc_keep  = (i == 40) ? 1'b1 : 1'b0;
        bus.out_ready = 1'b1;
      end else begin
        reset         = ($urandom_range(0, 199) == 0);
        bus.start     = ($urandom_range(0, 3) == 0);
        bus.mode_in   = 1'($urandom_range(0, 1));
        bus.k_len     = ($urandom_range(0, 4) == 0) ? KW'(0) : KW'($urandom_range(1, 6));
        bus.acc_keep  = 1'($urandom_range(0, 1));
        if (i < NCYC / 2) bus.out_ready = ($urandom_range(0, 3) != 0);
        else              bus.out_ready = ((i % 3) == 0);  // 1,0,0,1,0,0...
      end
      #1;

      // Expected outputs for this cycle.
      e_busy  = m_active;
      e_done  = 1'b0;
      e_feed  = 1'b0;
      e_en    = 1'b0;
      e_rst   = 1'b0;
      e_coe   = 1'b0;
      if (m_active) begin
        if (ph_q.size() > 0) begin
          e_rst  = (ph_q[0] == 0);
          e_feed = (ph_q[0] == 1);
          e_en   = (ph_q[0] != 0);
        end else if (drain_left > 0) begin
          e_coe = bus.out_ready;
        end else begin
          e_done = (last_valid < cyc);
        end
      end
      e_valid = (vt_q.size() > 0) && (vt_q[0] == cyc);

      check_eq("busy", bus.busy, e_busy);
      check_eq("done", bus.done, e_done);
      check_eq("feed_en", bus.feed_en, e_feed);
      check_eq("en_pre", bus.en_pre, e_en);
      check_eq("reset_pre", bus.reset_pre, e_rst);
      check_eq("cell_out_en_pre", bus.cell_out_en_pre, e_coe);
      check_eq("out_valid", bus.out_valid, e_valid);
      check_eq("mode", bus.mode, m_mode);
      check_eq("excl", 1'(32'(bus.reset_pre) + 32'(bus.en_pre) + 32'(bus.cell_out_en_pre) > 1),
               1'b0);
      if (bus.done === 1'b1) done_seen++;

      // Advance the model across the clock edge.
      if (e_valid) void'(vt_q.pop_front());
      if (reset) begin
        model_reset();
      end else if (!m_active) begin
        if (bus.start) begin
          m_active = 1'b1;
          m_mode   = bus.mode_in;
          if (!bus.acc_keep) ph_q.push_back(0);
          for (int k = 0; k < int'(bus.k_len); k++) ph_q.push_back(1);
          for (int k = 0; k < FLUSH; k++) ph_q.push_back(2);
          drain_left = bus.mode_in ? COLS : ROWS;
        end
      end else if (ph_q.size() > 0) begin
        void'(ph_q.pop_front());
      end else if (drain_left > 0) begin
        if (bus.out_ready) begin
          vt_q.push_back(cyc + DL);
          last_valid = cyc + DL;
          drain_left--;
        end
      end else if (e_done) begin
        m_active = 1'b0;
      end
    end

    check_eq("done_seen", 1'(done_seen > 0), 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
